sym_kbd_scan: RTL and testbench

- Reader side of the Symbolics console keyboard serial link.
- Periodically latches the keyboard's key-state shift register, clocks out NUM_KEYS state bits and compares each bit against the previous scan.
- Each changed key is emitted as a press/release event over a valid/ready handshake.
- Sits between the GPIO keyboard pins and the encoder logic in c5g_symenc.

---
 rtl/sym_kbd_scan.sv | 174 +++++++++++++++++
 tb/tb_sym_kbd_scan.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_kbd_scan.sv
// Symbolics console keyboard reader: latches and shifts NUM_KEYS key bits, emits one event per changed key.
// Event valid the clock after its CHECK cycle; a full event slot parks the shift clock low (STALL), nothing dropped.
module sym_kbd_scan #(
  parameter int CLK_DIV  = 50,
  parameter int NUM_KEYS = 128,
  parameter int KEY_W    = 7,
  parameter int SCAN_GAP = 1000
) (
  input  logic             clock,
  input  logic             reset,
  output logic             kbd_load,
  output logic             kbd_clk,
  input  logic             kbd_data,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [KEY_W-1:0] event_key,
  output logic             event_down,
  output logic             scan_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
  localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(NUM_KEYS - 1);

  typedef enum logic [2:0] {
    S_GAP, S_LOAD, S_CLK_LO, S_CHECK, S_STALL, S_CLK_HI
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             down;
  } kbd_evt_t;

  state_t                state, state_nxt;
  logic                  data_meta, data_sync;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_freeze, tick;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic [KEY_W-1:0]      bit_idx, idx_nxt;
  logic                  sample;
  logic [NUM_KEYS-1:0]   prev;
  logic                  slot_free, load_evt, done_nxt;
  kbd_evt_t              evt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      data_meta <= kbd_data;
      data_sync <= data_meta;
    end
  end

  // The half-bit divider pauses while a bit is being judged or held, so CLK_HI always gets a full tick.
  assign div_freeze = (state == S_CHECK) || (state == S_STALL);
  assign tick       = !div_freeze && (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!div_freeze) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign slot_free = !event_valid || event_ready;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    idx_nxt   = bit_idx;
    load_evt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt   = '0;
            state_nxt = S_LOAD;
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          idx_nxt   = '0;
          state_nxt = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (tick) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (sample == prev[bit_idx]) begin
          state_nxt = S_CLK_HI;
        end else if (slot_free) begin
          load_evt  = 1'b1;
          state_nxt = S_CLK_HI;
        end else begin
          state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (slot_free) begin
          load_evt  = 1'b1;
          state_nxt = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (tick) begin
          if (bit_idx == KEY_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_GAP;
          end else begin
            idx_nxt   = bit_idx + KEY_W'(1);
            state_nxt = S_CLK_LO;
          end
        end
      end
      default: state_nxt = S_GAP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_GAP;
      gap_cnt <= '0;
      bit_idx <= '0;
      sample  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      bit_idx <= idx_nxt;
      if (state == S_CLK_LO && tick) sample <= data_sync;
    end
  end

  // Pins are registered from the next state so they change cleanly with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_load  <= 1'b0;
      kbd_clk   <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      kbd_load  <= (state_nxt == S_LOAD);
      kbd_clk   <= !(state_nxt inside {S_CLK_LO, S_CHECK, S_STALL});
      scan_done <= done_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev        <= '0;
      evt_q       <= '0;
      event_valid <= 1'b0;
    end else begin
      if (load_evt) begin
        prev[bit_idx] <= sample;
        evt_q         <= '{key: bit_idx, down: sample};
        event_valid   <= 1'b1;
      end else if (event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

  assign event_key  = evt_q.key;
  assign event_down = evt_q.down;

endmodule

// File: tb/tb_sym_kbd_scan.sv
// Randomized bench: behavioural keyboard shift register plus a per-scan change list scoreboard.
module tb_sym_kbd_scan;

  localparam int CLK_DIV   = 4;
  localparam int NUM_KEYS  = 8;
  localparam int KEY_W     = 3;
  localparam int SCAN_GAP  = 2;
  localparam int SCAN_CLKS = (SCAN_GAP + 1 + 2 * NUM_KEYS) * CLK_DIV + NUM_KEYS;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             kbd_load, kbd_clk, kbd_data;
  logic             event_valid, event_down, scan_done;
  logic             event_ready = 1'b1;
  logic [KEY_W-1:0] event_key;

  always #5 clock = ~clock;

  sym_kbd_scan #(
    .CLK_DIV(CLK_DIV), .NUM_KEYS(NUM_KEYS), .KEY_W(KEY_W), .SCAN_GAP(SCAN_GAP)
  ) dut (
    .clock(clock), .reset(reset), .kbd_load(kbd_load), .kbd_clk(kbd_clk),
    .kbd_data(kbd_data), .event_valid(event_valid), .event_ready(event_ready),
    .event_key(event_key), .event_down(event_down), .scan_done(scan_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keyboard: parallel-loads the key map on kbd_load, shifts toward bit 0 on each kbd_clk rise.
  typedef struct { int key; bit down; } ev_t;
  ev_t                 exp_q[$];
  logic [NUM_KEYS-1:0] keys = '0, sh = '0, ref_prev = '0, con_prev = '0;
  logic                async_en = 1'b0, async_bit = 1'b0;
  int                  rises = 0, rise_total = 0;

  always @(posedge kbd_load) begin
    sh    = keys;
    rises = 0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keys[i] !== ref_prev[i]) exp_q.push_back('{key: i, down: keys[i]});
    ref_prev = keys;
  end

  always @(posedge kbd_clk) begin
    if (kbd_load !== 1'b1) sh = sh >> 1;
    rises++;
    rise_total++;
  end

  assign kbd_data = async_en ? async_bit : sh[0];

  initial forever begin
    #($urandom_range(1, 23));
    async_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: handshake, hold-stability, scoreboard and scan timing, all sampled on the falling edge.
  int               ready_mode = 0;
  bit               async_scb = 1'b0, measure = 1'b0;
  bit               held = 1'b0, done_seen = 1'b0;
  logic [KEY_W-1:0] held_key;
  logic             held_down;
  int               last_key = -1, accepted = 0, scans = 0;
  int               cyc = 0, last_done_cyc = 0, load_clks = 0, rise_mark = 0;
  ev_t              mon_e;

  always @(negedge clock) begin
    case (ready_mode)
      0:       event_ready = 1'b1;
      1:       event_ready = 1'b0;
      2:       event_ready = ~event_ready;
      default: event_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset) begin
      held      = 1'b0;
      done_seen = 1'b0;
      last_key  = -1;
    end else begin
      check_eq("no_x", 32'($isunknown({event_valid, event_key, event_down, kbd_clk, kbd_load, scan_done})), 0);
      if (held) begin
        check_eq("hold_valid", event_valid, 1);
        check_eq("hold_key", event_key, held_key);
        check_eq("hold_down", event_down, held_down);
      end
      if (event_valid && event_ready) begin
        accepted++;
        if (async_scb) begin
          check_eq("async_chg", event_down, !con_prev[event_key]);
          check_eq("async_order", int'(event_key) > last_key, 1);
        end else begin
          check_eq("evt_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("evt_key", event_key, mon_e.key);
            check_eq("evt_down", event_down, mon_e.down);
          end
        end
        con_prev[event_key] = event_down;
        last_key = int'(event_key);
      end
      held      = event_valid && !event_ready;
      held_key  = event_key;
      held_down = event_down;
      if (kbd_load) load_clks++;
      if (scan_done) begin
        if (measure && done_seen) begin
          check_eq("scan_period", cyc - last_done_cyc, SCAN_CLKS);
          check_eq("load_clks", load_clks, CLK_DIV);
          check_eq("clk_rises", rise_total - rise_mark, NUM_KEYS);
        end
        done_seen     = 1'b1;
        last_done_cyc = cyc;
        load_clks     = 0;
        rise_mark     = rise_total;
        last_key      = -1;
        scans++;
      end
    end
    cyc++;
  end

  task automatic wait_scans(input int n);
    int s0 = scans;
    int c  = 0;
    while (scans < s0 + n && c < 600 * n) begin
      @(negedge clock);
      c++;
    end
    check_eq("scan_timeout", scans >= s0 + n, 1);
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || event_valid) && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    ref_prev = '0;
    con_prev = '0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear_model();
    reset = 1'b0;
  endtask

  initial begin
    int a0, c;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_load", kbd_load, 0);
    check_eq("rst_clk", kbd_clk, 1);
    check_eq("rst_valid", event_valid, 0);
    check_eq("rst_key", event_key, 0);
    check_eq("rst_down", event_down, 0);
    check_eq("rst_done", scan_done, 0);
    clear_model();
    reset = 1'b0;

    // Idle keyboard: timing only, no events
    measure = 1'b1;
    a0 = accepted;
    wait_scans(3);
    check_eq("idle_evts", accepted - a0, 0);
    measure = 1'b0;

    // Single key press, quiet scan, release
    keys = 8'h08;
    a0 = accepted;
    wait_scans(1);
    drain("key3_drain");
    check_eq("key3_press_cnt", accepted - a0, 1);
    a0 = accepted;
    wait_scans(1);
    check_eq("key3_quiet_cnt", accepted - a0, 0);
    keys = 8'h00;
    wait_scans(1);
    drain("key3_rel_drain");
    check_eq("key3_rel_cnt", accepted - a0, 1);

    // Backpressure: key 1 held in the slot, key 2 stalls the shift clock low
    ready_mode = 1;
    do_reset();
    keys = 8'b0010_0110;
    c = 0;
    while (!kbd_load && c < 500) begin @(negedge clock); c++; end
    check_eq("stall_load_seen", kbd_load, 1);
    repeat (40) @(negedge clock);
    check_eq("stall_clk_low", kbd_clk, 0);
    check_eq("stall_bit", rises, 2);
    check_eq("stall_valid", event_valid, 1);
    check_eq("stall_key", event_key, 1);
    a0 = accepted;
    ready_mode = 0;
    wait_scans(1);
    drain("stall_drain");
    check_eq("stall_cnt", accepted - a0, 3);

    // All keys down with ready toggling every cycle
    ready_mode = 2;
    do_reset();
    keys = 8'hFF;
    a0 = accepted;
    wait_scans(1);
    ready_mode = 0;
    drain("toggle_drain");
    check_eq("toggle_cnt", accepted - a0, 8);

    // Reset mid-shift at bit 4 with an event held
    ready_mode = 1;
    do_reset();
    keys = 8'h01;
    c = 0;
    while (!(rises == 4 && kbd_clk === 1'b0 && event_valid === 1'b1) && c < 500) begin
      @(negedge clock);
      c++;
    end
    check_eq("mid_reached", rises == 4 && event_valid === 1'b1, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("mid_rst_valid", event_valid, 0);
    check_eq("mid_rst_clk", kbd_clk, 1);
    check_eq("mid_rst_load", kbd_load, 0);
    clear_model();
    keys = NUM_KEYS'($urandom_range(1, 255));
    ready_mode = 3;
    @(posedge clock);
    #1 reset = 1'b0;
    a0 = accepted;
    wait_scans(1);
    ready_mode = 0;
    drain("mid_drain");
    check_eq("mid_repress_cnt", accepted - a0, $countones(keys));

    // Random key maps and random readiness
    ready_mode = 3;
    for (int s = 0; s < 6; s++) begin
      keys = NUM_KEYS'($urandom);
      wait_scans(1);
    end
    ready_mode = 0;
    drain("rand_drain");

    // Data toggling asynchronously: each event must be a real change of the reported state
    async_scb = 1'b1;
    async_en  = 1'b1;
    wait_scans(3);
    async_en  = 1'b0;
    ref_prev  = con_prev;
    exp_q.delete();
    async_scb = 1'b0;
    keys = NUM_KEYS'($urandom);
    wait_scans(2);
    drain("async_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
